nvram_upload_ctrl: RTL and testbench
====================================

# nvram_upload_ctrl

Handles the save direction of the HPS file channel for the Williams-2 core's battery-backed CMOS (1K x 4). It answers HPS upload reads by fetching nibbles from a CMOS read port, and requests an automatic upload after the game has stopped writing CMOS. It also restores CMOS from a download with the same index. It sits between `hps_io` and the williams2 core's second CMOS port, alongside the ROM download path.

## Interface
Parameters:
- `ADDR_W`, 10, CMOS address width; DEPTH = 2^ADDR_W bytes per file.
- `DATA_W`, 4, CMOS data width; must be ≤ 8.
- `NV_INDEX`, 8'd4, `ioctl_index` value that selects the NVRAM file.
- `QUIET_CYC`, 12_000_000, cycles with no game CMOS write before an upload is requested (1 s at 12 MHz).

Ports:
- `clk_sys`  in  1  sole clock (12 MHz core clock).
- `reset`  in  1  synchronous, active-high.
- `ioctl_upload`  in  1  HPS upload active.
- `ioctl_download`  in  1  HPS download active.
- `ioctl_index`  in  8  file index.
- `ioctl_addr`  in  17  byte address.
- `ioctl_rd`  in  1  upload read strobe, 1 cycle.
- `ioctl_wr`  in  1  download write strobe, 1 cycle.
- `ioctl_dout`  in  8  download data.
- `ioctl_din`  out  8  upload data.
- `ioctl_wait`  out  1  stalls HPS while a fetch is in progress.
- `ioctl_upload_req`  out  1  request for HPS to start an NVRAM upload.
- `nv_addr`  out  ADDR_W  CMOS port address.
- `nv_rd`  out  1  CMOS read enable; data returns 1 cycle later.
- `nv_din`  in  DATA_W  CMOS read data.
- `nv_we`  out  1  CMOS write enable.
- `nv_dout`  out  DATA_W  CMOS write data.
- `nv_we_mon`  in  1  pulses when the game CPU writes CMOS.

## Operation
- Selection:
  - `up_sel = ioctl_upload & ioctl_index==NV_INDEX`.
  - `dn_sel = ioctl_download & ioctl_index==NV_INDEX`.
  - If both are high, `dn_sel` wins and `up_sel` is treated as 0.
- Read FSM, states IDLE → ADDR → DATA → IDLE:
  - IDLE, when `ioctl_rd & up_sel`:
    - register `nv_addr = ioctl_addr[ADDR_W-1:0]`;
    - `nv_rd=1`, `ioctl_wait=1`;
    - go to ADDR.
  - ADDR: `nv_rd=0`, wait for RAM latency; go to DATA.
  - DATA:
    - `ioctl_din = {zero-pad, nv_din}` if `ioctl_addr < DEPTH` at capture, else 8'h00;
    - `ioctl_wait=0`; go to IDLE.
  - Out-of-range addresses take the same path and the same latency.
  - `ioctl_rd` seen outside IDLE is ignored; the HPS honours `ioctl_wait`.
- Restore: on `ioctl_wr & dn_sel & ioctl_addr < DEPTH`:
  - next cycle `nv_we=1` for 1 cycle, `nv_addr=ioctl_addr[ADDR_W-1:0]`, `nv_dout=ioctl_dout[DATA_W-1:0]`;
  - out-of-range writes are dropped.
- Dirty tracking:
  - `nv_we_mon`: sets `dirty` and loads `quiet = QUIET_CYC`.
  - Otherwise `quiet` decrements to 0 and saturates. Width is `$clog2(QUIET_CYC+1)`.
- Upload request:
  - `ioctl_upload_req` is set when `dirty & quiet==0 & !ioctl_upload & !ioctl_download`.
  - It holds high until a rising edge of `up_sel` is seen.
  - That edge clears `dirty` and `ioctl_upload_req`.
- `dn_sel` high clears `dirty`, `quiet` and `ioctl_upload_req`, since restored data is already on disk.
- `nv_we_mon` during an upload sets `dirty` again and reloads `quiet`. A new request follows `QUIET_CYC` cycles after the last such write, once the upload has ended.
- Reset:
  - all outputs go to 0; FSM to IDLE; `dirty=0`, `quiet=0`;
  - a reset in ADDR or DATA abandons the fetch and drops `ioctl_wait` the next cycle.

## Timing
- All outputs are registered.
- Read: `ioctl_rd` sampled high at edge T.
  - `nv_rd`/`nv_addr` valid T+1..T+2 (`nv_rd` high only in T+1).
  - `ioctl_wait` high T+1..T+2.
  - `ioctl_din` valid and `ioctl_wait` low from T+3.
  - Throughput: 1 byte per 3 cycles minimum.
- Restore: `ioctl_wr` at T → `nv_we` high exactly in T+1.
- Request: the last `nv_we_mon` at T leaves `quiet==0` at T+QUIET_CYC; `ioctl_upload_req` rises at T+QUIET_CYC+1.
- A `nv_we_mon` in the same cycle that `quiet` hits 0 reloads `quiet`, and no request is issued.
- `up_sel` rise at T → `ioctl_upload_req` low at T+1.

## Test plan
- Reset, then idle 100 cycles → all outputs 0, no request.
- Preload CMOS[5]=4'hA, upload index 4, `ioctl_rd` with addr 5 → `nv_rd` at T+1, wait high for 2 cycles, `ioctl_din`=8'h0A at T+3; addr 1024 → 8'h00 with the same latency.
- Download index 4 of bytes 8'h37 at addr 0..1023 plus a byte at 1030 → 1024 `nv_we` pulses with `nv_dout`=4'h7, none for 1030; `dirty` clear afterwards.
- QUIET_CYC=100: `nv_we_mon` at cycles 0 and 50 → `ioctl_upload_req` rises at 151 and holds until `up_sel` rises, then falls next cycle.
- `nv_we_mon` during an active upload → no request while `ioctl_upload` is high; request QUIET_CYC+1 cycles after the write once the upload has ended.
- Assert `reset` in ADDR state → `ioctl_wait`=0 and FSM IDLE next cycle; the next `ioctl_rd` completes normally. Index 0 (ROM) activity is ignored: no `nv_we`, no wait.

Source files
------------

// File: rtl/nvram_upload_ctrl.sv
// rtl/nvram_upload_ctrl.sv - HPS save/restore bridge for the battery-backed CMOS with automatic upload request
module nvram_upload_ctrl #(
    parameter int          ADDR_W    = 10,
    parameter int          DATA_W    = 4,
    parameter logic [7:0]  NV_INDEX  = 8'd4,
    parameter int          QUIET_CYC = 12_000_000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic [16:0]       ioctl_addr,
    input  logic              ioctl_rd,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              ioctl_upload_req,
    output logic [ADDR_W-1:0] nv_addr,
    output logic              nv_rd,
    input  logic [DATA_W-1:0] nv_din,
    output logic              nv_we,
    output logic [DATA_W-1:0] nv_dout,
    input  logic              nv_we_mon
);

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);
    localparam int          QW    = $clog2(QUIET_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [QW-1:0]   quiet;
    logic            dirty;
    logic            up_sel_q;
    logic            rd_in_range;

    logic            index_hit;
    logic            dn_sel;
    logic            up_sel;
    logic            up_rise;
    logic            in_range;
    logic            rd_start;
    logic            wr_hit;
    logic            unused_dout;

    assign index_hit   = (ioctl_index == NV_INDEX);
    assign dn_sel      = ioctl_download & index_hit;
    // A download on the NVRAM index always takes precedence over an upload.
    assign up_sel      = ioctl_upload & index_hit & ~dn_sel;
    assign up_rise     = up_sel & ~up_sel_q;
    assign in_range    = (ioctl_addr < DEPTH);
    assign rd_start    = (state == S_IDLE) & ioctl_rd & up_sel;
    assign wr_hit      = ioctl_wr & dn_sel & in_range;
    assign unused_dout = ^ioctl_dout;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (rd_start) state_n = S_ADDR;
            S_ADDR:  state_n = S_DATA;
            S_DATA:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state            <= S_IDLE;
            ioctl_din        <= 8'h00;
            ioctl_wait       <= 1'b0;
            ioctl_upload_req <= 1'b0;
            nv_addr          <= '0;
            nv_rd            <= 1'b0;
            nv_we            <= 1'b0;
            nv_dout          <= '0;
            quiet            <= '0;
            dirty            <= 1'b0;
            up_sel_q         <= 1'b0;
            rd_in_range      <= 1'b0;
        end else begin
            state      <= state_n;
            ioctl_wait <= (state_n != S_IDLE);
            nv_rd      <= rd_start;
            nv_we      <= wr_hit;
            up_sel_q   <= up_sel;

            if (rd_start) begin
                nv_addr     <= ioctl_addr[ADDR_W-1:0];
                rd_in_range <= in_range;
            end else if (wr_hit) begin
                nv_addr <= ioctl_addr[ADDR_W-1:0];
                nv_dout <= ioctl_dout[DATA_W-1:0];
            end

            // Out-of-range fetches still run the full pipeline so latency is uniform.
            if (state == S_DATA) begin
                ioctl_din <= rd_in_range ? 8'(nv_din) : 8'h00;
            end

            if (dn_sel) begin
                dirty            <= 1'b0;
                quiet            <= '0;
                ioctl_upload_req <= 1'b0;
            end else begin
                if (nv_we_mon) begin
                    dirty <= 1'b1;
                    quiet <= QW'(QUIET_CYC);
                end else begin
                    if (up_rise) dirty <= 1'b0;
                    if (quiet != '0) quiet <= quiet - QW'(1);
                end
                // A game write landing as the timer expires restarts the quiet period.
                if (up_rise) begin
                    ioctl_upload_req <= 1'b0;
                end else if (dirty && (quiet == '0) && !nv_we_mon &&
                             !ioctl_upload && !ioctl_download) begin
                    ioctl_upload_req <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nvram_upload_ctrl.sv
// tb/tb_nvram_upload_ctrl.sv - randomized self-checking bench for nvram_upload_ctrl
module tb_nvram_upload_ctrl;

    localparam int Q = 100;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic [16:0] ioctl_addr;
    logic        ioctl_rd;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        ioctl_upload_req;
    logic [9:0]  nv_addr;
    logic        nv_rd;
    logic [3:0]  nv_din;
    logic        nv_we;
    logic [3:0]  nv_dout;
    logic        nv_we_mon;

    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [3:0]  pre_data;
    logic [3:0]  ram     [1024];
    logic [3:0]  ref_mem [1024];

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    always #5 clk_sys = ~clk_sys;

    nvram_upload_ctrl #(
        .ADDR_W    (10),
        .DATA_W    (4),
        .NV_INDEX  (8'd4),
        .QUIET_CYC (Q)
    ) dut (
        .clk_sys          (clk_sys),
        .reset            (reset),
        .ioctl_upload     (ioctl_upload),
        .ioctl_download   (ioctl_download),
        .ioctl_index      (ioctl_index),
        .ioctl_addr       (ioctl_addr),
        .ioctl_rd         (ioctl_rd),
        .ioctl_wr         (ioctl_wr),
        .ioctl_dout       (ioctl_dout),
        .ioctl_din        (ioctl_din),
        .ioctl_wait       (ioctl_wait),
        .ioctl_upload_req (ioctl_upload_req),
        .nv_addr          (nv_addr),
        .nv_rd            (nv_rd),
        .nv_din           (nv_din),
        .nv_we            (nv_we),
        .nv_dout          (nv_dout),
        .nv_we_mon        (nv_we_mon)
    );

    // CMOS second port: synchronous read with one cycle of latency.
    always @(posedge clk_sys) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (nv_we) ram[nv_addr] <= nv_dout;
        if (nv_rd) nv_din <= ram[nv_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        edge_n++;
        #1;
    endtask

    task automatic do_read(input logic [16:0] a);
        logic [7:0] exp;
        exp = (a < 17'd1024) ? {4'h0, ref_mem[a[9:0]]} : 8'h00;
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        tick;
        ioctl_rd = 1'b0;
        chk("rd_nv_rd_t1", nv_rd, 1);
        chk("rd_wait_t1", ioctl_wait, 1);
        chk("rd_nv_addr", nv_addr, a[9:0]);
        tick;
        chk("rd_nv_rd_t2", nv_rd, 0);
        chk("rd_wait_t2", ioctl_wait, 1);
        tick;
        chk("rd_wait_t3", ioctl_wait, 0);
        chk("rd_din", ioctl_din, exp);
    endtask

    task automatic do_write(input logic [16:0] a, input logic [7:0] d);
        logic hit;
        hit = ioctl_download && (ioctl_index == 8'd4) && (a < 17'd1024);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick;
        ioctl_wr = 1'b0;
        chk("wr_we", nv_we, hit);
        if (hit) begin
            chk("wr_addr", nv_addr, a[9:0]);
            chk("wr_data", nv_dout, d[3:0]);
            ref_mem[a[9:0]] = d[3:0];
        end
        tick;
        chk("wr_we_off", nv_we, 0);
    endtask

    // Request expected once the upload is off and Q+1 edges have passed the last game write.
    task automatic req_window(input int n, input int up_len, input int mon_a, input int mon_b);
        int   last;
        int   d_edge;
        logic exp;
        last   = -1;
        d_edge = 32'h7fff_ffff;
        ioctl_index    = 8'd4;
        ioctl_download = 1'b0;
        for (int i = 0; i < n; i++) begin
            ioctl_upload = (i < up_len);
            nv_we_mon    = (i == mon_a) || (i == mon_b);
            tick;
            nv_we_mon = 1'b0;
            if (i == mon_a || i == mon_b) last = edge_n;
            if (i == up_len) d_edge = edge_n;
            exp = (last >= 0) && (edge_n >= last + Q + 1) && (edge_n >= d_edge);
            chk("upload_req", ioctl_upload_req, exp);
        end
        ioctl_upload = 1'b0;
    endtask

    initial begin
        int ul;
        reset = 1'b1;
        ioctl_upload = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0;
        ioctl_addr = '0; ioctl_rd = 1'b0; ioctl_wr = 1'b0; ioctl_dout = '0;
        nv_we_mon = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        for (int i = 0; i < 1024; i++) begin
            pre_we   = 1'b1;
            pre_addr = 10'(i);
            pre_data = (i == 5) ? 4'hA : 4'($urandom);
            ref_mem[i] = pre_data;
            tick;
        end
        pre_we = 1'b0;
        tick;
        reset = 1'b0;

        for (int i = 0; i < 100; i++) begin
            tick;
            chk("idle_outputs", {ioctl_din, ioctl_wait, ioctl_upload_req, nv_addr,
                                 nv_rd, nv_we, nv_dout}, 0);
        end

        ioctl_index = 8'd4; ioctl_upload = 1'b1;
        tick;
        do_read(17'd5);
        do_read(17'd1024);
        do_read(17'h10005);
        do_read(17'd1023);
        ioctl_upload = 1'b0;

        // ROM index traffic must not touch CMOS.
        ioctl_index = 8'd0; ioctl_upload = 1'b1;
        ioctl_addr = 17'd5; ioctl_rd = 1'b1;
        tick;
        ioctl_rd = 1'b0;
        chk("rom_rd_wait", ioctl_wait, 0);
        chk("rom_rd_nv_rd", nv_rd, 0);
        tick;
        chk("rom_rd_wait2", ioctl_wait, 0);
        ioctl_upload = 1'b0; ioctl_download = 1'b1;
        do_write(17'd3, 8'h55);
        ioctl_download = 1'b0;

        ioctl_index = 8'd4; ioctl_upload = 1'b1;
        ioctl_addr = 17'd7; ioctl_rd = 1'b1;
        tick;
        ioctl_rd = 1'b0;
        chk("rst_addr_wait_pre", ioctl_wait, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rst_addr_wait", ioctl_wait, 0);
        chk("rst_addr_nv_rd", nv_rd, 0);
        do_read(17'd7);
        ioctl_upload = 1'b0;
        tick;

        // Dirty from a game write is discarded by the restore that follows.
        nv_we_mon = 1'b1;
        tick;
        nv_we_mon = 1'b0;
        ioctl_download = 1'b1;
        for (int a = 0; a < 1024; a++) do_write(17'(a), 8'h37);
        do_write(17'd1030, 8'h37);
        ioctl_download = 1'b0;
        req_window(Q + 20, 0, -1, -1);

        ioctl_download = 1'b1;
        for (int i = 0; i < 40; i++) do_write(17'($urandom_range(0, 1100)), 8'($urandom));
        ioctl_download = 1'b0;
        ioctl_upload = 1'b1;
        tick;
        for (int i = 0; i < 40; i++) do_read(17'($urandom_range(0, 1100)));
        do_read(17'h1FFFF);
        ioctl_upload = 1'b0;
        tick;

        req_window(50 + Q + 20, 0, 0, 50);
        req_window(30 + Q + 40, 30, 5, -1);
        ul = $urandom_range(150, 250);
        req_window(ul + Q + 40, ul, $urandom_range(1, ul - 1), -1);
        ul = $urandom_range(10, 60);
        req_window(ul + Q + 40, ul, $urandom_range(1, ul - 1), $urandom_range(1, ul - 1));
        req_window(Q + 20, 3, -1, -1);
        req_window(2 * Q + 20, 0, 0, Q + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
